// File: rtl/mips_cpu_definitions.sv
// Shared types and constants for the MIPS CPU bus interface logic.
package mips_cpu_definitions;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_FETCH,
      ARB_DATA
   } arb_state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_starve_counter.sv
// Saturating counter of arbitration losses suffered by a pending fetch.
module mips_bus_starve_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] count,
   output logic       at_limit
);

   localparam logic [3:0] LIMIT_4 = 4'(LIMIT);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LIMIT_4)) begin
         count <= count + 4'd1;
      end
   end

   assign at_limit = (count == LIMIT_4);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates the single Avalon master port between instruction fetch and data access.
module mips_bus_arbiter
   import mips_cpu_definitions::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        grant_data,
   output logic        protocol_error
);

   localparam logic [3:0] LIMIT_4 = 4'(STARVE_LIMIT);

   arb_state_t state;
   logic       data_req;
   logic       data_both;
   logic       fetch_wins;
   logic       starve_inc;
   logic       starve_clr;
   logic [3:0] starve_cnt;
   logic       starve_at_limit;

   assign data_req   = d_read ^ d_write;
   assign data_both  = d_read & d_write;
   assign fetch_wins = i_read && (!data_req || starve_at_limit);
   assign starve_clr = (state == ARB_IDLE) && fetch_wins;
   assign starve_inc = (state == ARB_IDLE) && i_read && data_req && (starve_cnt != LIMIT_4);

   mips_bus_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .count    (starve_cnt),
      .at_limit (starve_at_limit)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ARB_IDLE;
         protocol_error <= 1'b0;
      end else begin
         if (data_both) protocol_error <= 1'b1;
         case (state)
            ARB_IDLE: begin
               if (fetch_wins)    state <= ARB_FETCH;
               else if (data_req) state <= ARB_DATA;
            end
            ARB_FETCH, ARB_DATA: begin
               // Grant is held until the slave accepts; a dropped request cannot abort it.
               if (!waitrequest) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      address       = '0;
      read          = 1'b0;
      write         = 1'b0;
      writedata     = '0;
      byteenable    = '0;
      grant_data    = 1'b0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;
      case (state)
         ARB_FETCH: begin
            address       = i_address;
            read          = 1'b1;
            byteenable    = BE_WORD;
            i_readdata    = readdata;
            i_waitrequest = waitrequest;
         end
         ARB_DATA: begin
            address       = d_address;
            read          = d_read;
            write         = d_write;
            writedata     = d_writedata;
            byteenable    = d_byteenable;
            grant_data    = 1'b1;
            d_readdata    = readdata;
            d_waitrequest = waitrequest;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: directed requests, monitor checks each completed bus transfer.
module tb_mips_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        grant_data;
   logic        protocol_error;

   typedef struct {
      logic        is_data;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t exp_q[$];
   int   checks      = 0;
   int   failures    = 0;
   int   completions = 0;

   mips_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_address      (i_address),
      .i_read         (i_read),
      .i_waitrequest  (i_waitrequest),
      .i_readdata     (i_readdata),
      .d_address      (d_address),
      .d_read         (d_read),
      .d_write        (d_write),
      .d_writedata    (d_writedata),
      .d_byteenable   (d_byteenable),
      .d_waitrequest  (d_waitrequest),
      .d_readdata     (d_readdata),
      .address        (address),
      .read           (read),
      .write          (write),
      .writedata      (writedata),
      .byteenable     (byteenable),
      .waitrequest    (waitrequest),
      .readdata       (readdata),
      .grant_data     (grant_data),
      .protocol_error (protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic txn_t fetch_txn(input logic [31:0] a, input logic [31:0] rd_val);
      txn_t t;
      t = '{is_data: 1'b0, addr: a, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0, rdata: rd_val};
      return t;
   endfunction

   function automatic txn_t data_txn(input logic [31:0] a, input logic r, input logic w,
                                     input logic [3:0] b, input logic [31:0] wd, input logic [31:0] rd_val);
      txn_t t;
      t = '{is_data: 1'b1, addr: a, rd: r, wr: w, be: b, wdata: wd, rdata: rd_val};
      return t;
   endfunction

   // Monitor: every accepted bus transfer must match the next expected transaction.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && (read === 1'b1 || write === 1'b1) && waitrequest === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_txn: got address %h grant_data %b expected no transfer", address, grant_data);
            end else begin
               e = exp_q.pop_front();
               check("txn_grant_data", {31'b0, grant_data}, {31'b0, e.is_data});
               check("txn_address", address, e.addr);
               check("txn_read", {31'b0, read}, {31'b0, e.rd});
               check("txn_write", {31'b0, write}, {31'b0, e.wr});
               check("txn_byteenable", {28'b0, byteenable}, {28'b0, e.be});
               check("txn_writedata", writedata, e.wdata);
               if (e.is_data) begin
                  check("txn_d_waitrequest", {31'b0, d_waitrequest}, 32'd0);
                  check("txn_d_readdata", d_readdata, e.rdata);
                  check("txn_i_waitrequest", {31'b0, i_waitrequest}, 32'd1);
                  check("txn_i_readdata", i_readdata, 32'd0);
               end else begin
                  check("txn_i_waitrequest", {31'b0, i_waitrequest}, 32'd0);
                  check("txn_i_readdata", i_readdata, e.rdata);
                  check("txn_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);
                  check("txn_d_readdata", d_readdata, 32'd0);
               end
            end
            completions++;
         end
      end
   end

   // Returns on the posedge right after the target completion, then steps #1 past it.
   task automatic wait_completions(input int target, input int budget);
      int c;
      c = 0;
      while (completions < target && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      checks++;
      if (completions < target) begin
         failures++;
         $display("FAIL wait_completions: got %0d expected %0d", completions, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      reset        = 1'b0;
      i_read       = 1'b1;
      i_address    = 32'hBFC00000;
      d_read       = 1'b1;
      d_write      = 1'b0;
      d_address    = 32'h00001000;
      d_byteenable = 4'hF;
      d_writedata  = 32'h0;
      waitrequest  = 1'b0;
      readdata     = 32'h24020005;

      // Reset held with both requests pending keeps the bus idle.
      repeat (3) begin
         @(negedge clk);
         check("rst_read", {31'b0, read}, 32'd0);
         check("rst_write", {31'b0, write}, 32'd0);
         check("rst_i_waitrequest", {31'b0, i_waitrequest}, 32'd1);
         check("rst_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);
         check("rst_grant_data", {31'b0, grant_data}, 32'd0);
      end

      // Continuous contention: D,D,D,D,F,D,D,D,D,F.
      repeat (2) begin
         repeat (4) exp_q.push_back(data_txn(32'h00001000, 1'b1, 1'b0, 4'hF, 32'h0, 32'h24020005));
         exp_q.push_back(fetch_txn(32'hBFC00000, 32'h24020005));
      end
      @(posedge clk); #1;
      reset = 1'b1;
      wait_completions(10, 200);
      i_read = 1'b0;
      d_read = 1'b0;
      check("contention_no_perr", {31'b0, protocol_error}, 32'd0);

      // Fetch only, zero-wait slave.
      @(posedge clk); #1;
      i_read   = 1'b1;
      readdata = 32'h24020005;
      exp_q.push_back(fetch_txn(32'hBFC00000, 32'h24020005));
      @(negedge clk);
      check("fetch_req_cycle_read", {31'b0, read}, 32'd0);
      @(negedge clk);
      check("fetch_bus_read", {31'b0, read}, 32'd1);
      check("fetch_bus_address", address, 32'hBFC00000);
      check("fetch_bus_be", {28'b0, byteenable}, 32'hF);
      check("fetch_i_waitrequest", {31'b0, i_waitrequest}, 32'd0);
      check("fetch_i_readdata", i_readdata, 32'h24020005);
      @(posedge clk); #1;
      i_read = 1'b0;
      @(negedge clk);
      check("fetch_after_i_waitrequest", {31'b0, i_waitrequest}, 32'd1);
      check("fetch_after_read", {31'b0, read}, 32'd0);

      // Store stalled three cycles by the slave.
      @(posedge clk); #1;
      d_address    = 32'h00001004;
      d_byteenable = 4'b0011;
      d_writedata  = 32'h0000BEEF;
      d_write      = 1'b1;
      waitrequest  = 1'b1;
      readdata     = 32'h0;
      exp_q.push_back(data_txn(32'h00001004, 1'b0, 1'b1, 4'b0011, 32'h0000BEEF, 32'h0));
      @(negedge clk);
      check("store_req_cycle_write", {31'b0, write}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("store_stall_write", {31'b0, write}, 32'd1);
         check("store_stall_address", address, 32'h00001004);
         check("store_stall_be", {28'b0, byteenable}, 32'h3);
         check("store_stall_writedata", writedata, 32'h0000BEEF);
         check("store_stall_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);
      end
      @(posedge clk); #1;
      waitrequest = 1'b0;
      @(negedge clk);
      check("store_final_write", {31'b0, write}, 32'd1);
      check("store_final_d_waitrequest", {31'b0, d_waitrequest}, 32'd0);
      @(posedge clk); #1;
      d_write = 1'b0;
      @(negedge clk);
      check("store_after_write", {31'b0, write}, 32'd0);
      check("store_after_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);

      // Illegal read+write from data: flagged, ignored, fetch still served.
      @(posedge clk); #1;
      d_read    = 1'b1;
      d_write   = 1'b1;
      i_read    = 1'b1;
      i_address = 32'hBFC00010;
      readdata  = 32'h8C430000;
      exp_q.push_back(fetch_txn(32'hBFC00010, 32'h8C430000));
      @(negedge clk);
      check("perr_req_cycle_read", {31'b0, read}, 32'd0);
      @(negedge clk);
      check("perr_flag_set", {31'b0, protocol_error}, 32'd1);
      check("perr_fetch_read", {31'b0, read}, 32'd1);
      check("perr_grant_data", {31'b0, grant_data}, 32'd0);
      @(posedge clk); #1;
      d_read  = 1'b0;
      d_write = 1'b0;
      i_read  = 1'b0;
      repeat (3) @(negedge clk);
      check("perr_sticky", {31'b0, protocol_error}, 32'd1);
      check("perr_idle_write", {31'b0, write}, 32'd0);

      // Reset while a store is stalled; afterwards contention must restart from a cleared counter.
      @(posedge clk); #1;
      i_read       = 1'b1;
      d_write      = 1'b1;
      d_address    = 32'h00001004;
      d_byteenable = 4'b0011;
      d_writedata  = 32'h0000BEEF;
      waitrequest  = 1'b1;
      readdata     = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check("rstmid_stalled_write", {31'b0, write}, 32'd1);
      check("rstmid_stalled_grant", {31'b0, grant_data}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_before_edge_write", {31'b0, write}, 32'd1);
      repeat (4) exp_q.push_back(data_txn(32'h00001004, 1'b0, 1'b1, 4'b0011, 32'h0000BEEF, 32'h0));
      exp_q.push_back(fetch_txn(32'hBFC00010, 32'h0));
      base = completions;
      @(posedge clk); #1;
      reset       = 1'b1;
      waitrequest = 1'b0;
      @(negedge clk);
      check("rstmid_write_dropped", {31'b0, write}, 32'd0);
      check("rstmid_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);
      check("rstmid_i_waitrequest", {31'b0, i_waitrequest}, 32'd1);
      check("rstmid_grant_data", {31'b0, grant_data}, 32'd0);
      check("rstmid_perr_cleared", {31'b0, protocol_error}, 32'd0);
      wait_completions(base + 5, 100);
      i_read  = 1'b0;
      d_write = 1'b0;

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      check("final_idle_read", {31'b0, read}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-requester arbiter sharing the CPU's single Avalon memory-mapped master port between the instruction-fetch requester (read-only) and the data requester (loads and stores).
- Sits between the CPU core's fetch and load/store logic and the external Avalon bus.
- Grants are registered and held until the granted transaction completes (downstream waitrequest low).
- Default priority goes to data; a starvation counter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive arbitration losses by a pending fetch after which fetch wins the next arbitration (legal range 1..15)

Ports:
clk  in  1  system clock; all state changes on posedge clk
reset  in  1  synchronous, active-low reset (reset==0 resets on the next posedge clk)
i_address  in  32  fetch address
i_read  in  1  fetch read request
i_waitrequest  out  1  fetch stall
i_readdata  out  32  fetch read data
d_address  in  32  data address
d_read  in  1  data read request
d_write  in  1  data write request
d_writedata  in  32  store data
d_byteenable  in  4  store/load byte lanes
d_waitrequest  out  1  data stall
d_readdata  out  32  load data
address  out  32  Avalon address
read  out  1  Avalon read
write  out  1  Avalon write
writedata  out  32  Avalon write data
byteenable  out  4  Avalon byte enables
waitrequest  in  1  Avalon slave stall
readdata  in  32  Avalon read data
grant_data  out  1  1 while data requester owns the bus (debug)
protocol_error  out  1  sticky flag: data requester asserted read and write together

Behaviour:
- States (arb_state_t): ARB_IDLE, ARB_FETCH, ARB_DATA.
- Reset (reset==0 at posedge):
  - state=ARB_IDLE, starve_cnt=0, protocol_error=0.
  - Outputs combinationally derive to read=0, write=0, byteenable=0, address=0, writedata=0, grant_data=0, i_waitrequest=1, d_waitrequest=1.
  - Reset mid-transaction abandons the transaction: bus strobes drop in the cycle after the reset edge and no completion is signalled to either requester.
- Data request valid = d_read XOR d_write. Both high sets protocol_error (sticky until reset) and is treated as no request.
- Fetch request valid = i_read.
- ARB_IDLE, arbitration each cycle:
  - Only one request valid: grant it.
  - Both valid: fetch wins if starve_cnt==STARVE_LIMIT, else data wins and starve_cnt increments (saturating at STARVE_LIMIT).
  - A fetch grant clears starve_cnt.
  - No request: stay in ARB_IDLE.
  - Bus outputs are idle in ARB_IDLE.
- ARB_FETCH:
  - address=i_address, read=1, write=0, byteenable=4'b1111, writedata=0.
  - i_readdata=readdata and i_waitrequest=waitrequest.
  - d_waitrequest=1.
- ARB_DATA:
  - address=d_address, read=d_read, write=d_write, byteenable=d_byteenable, writedata=d_writedata, grant_data=1.
  - d_readdata=readdata and d_waitrequest=waitrequest.
  - i_waitrequest=1.
- Completion: in a granted state with waitrequest==0 at posedge, return to ARB_IDLE.
  - The requester sees waitrequest low for exactly that one cycle.
  - Back-to-back grants therefore have a one-cycle idle bubble.
- Latency:
  - Request in cycle N (ARB_IDLE) drives the bus in cycle N+1.
  - With a zero-wait slave, the transaction completes at the end of N+1.
- Non-granted requester readdata outputs are 0.
- Requesters hold all request signals stable until their waitrequest is low (Avalon rule). The arbiter does not latch request payloads.
- A requester that drops its request while granted is a requester bug. The arbiter keeps the grant until waitrequest==0.

Decomposition:
- Shared package mips_cpu_definitions: typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_FETCH, ARB_DATA}.
- Shared package constant: BE_WORD=4'b1111.
- One sub-module: mips_bus_starve_counter. It is a saturating counter with inputs inc, clr and parameter LIMIT, and outputs count and at_limit.

Test Plan:
- Reset held low 3 cycles with both requests high -> read=0, write=0, i_waitrequest=1, d_waitrequest=1, grant_data=0. After release, the first grant is data.
- Fetch only, i_address=32'hBFC00000, zero-wait slave with readdata=32'h24020005 -> bus read at 32'hBFC00000 with byteenable 4'b1111 one cycle after request. i_readdata=32'h24020005 with i_waitrequest=0 for one cycle.
- Data store d_address=32'h00001004, d_byteenable=4'b0011, d_writedata=32'h0000BEEF, slave waitrequest high 3 cycles -> write held 4 cycles with stable payload. d_waitrequest falls only on cycle 4.
- Both requesting continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, repeating. Grant order D,D,D,D,F,D,D,D,D,F.
- d_read=1 and d_write=1 together -> protocol_error=1, no bus transaction, fetch still served. The flag stays set until reset.
- Reset asserted while ARB_DATA is stalled -> next cycle state ARB_IDLE, write=0, d_waitrequest=1, starve_cnt=0.
